// File: rtl/sram_arbiter.sv
// Two-port arbiter for a shared 16-bit asynchronous SRAM: instruction fetch (read-only)
// and data access (read/write). Each 32-bit word is moved as two halfword phases.
module sram_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    // instruction port
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    // SRAM pins
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    // FSM observation
    output logic [1:0]        state_dbg
);

    // Handshake: a requester raises req with address/data stable and holds it until the
    // matching one-cycle ack; the transaction is accepted on the edge where the FSM
    // leaves IDLE and uses the copies latched then, so later input changes are ignored.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              grant_d, grant_d_nx;
    logic              last_grant_d, last_grant_d_nx;
    logic              txn_we, txn_we_nx;
    logic [ADDR_W-2:0] txn_addr, txn_addr_nx;
    logic [31:0]       txn_wdata, txn_wdata_nx;
    logic [15:0]       rd_lo;

    logic              phase_end;
    logic              busy_nx;
    logic              half_nx;
    logic              we_n_nx;
    logic              oe_nx;
    logic              ack_nx;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+1], i_addr[1:0],
                                d_addr[31:ADDR_W+1], d_addr[1:0]};

    assign d_ready   = ~(d_req & ~d_ack);
    assign state_dbg = state;

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        grant_d_nx      = grant_d;
        last_grant_d_nx = last_grant_d;
        txn_we_nx       = txn_we;
        txn_addr_nx     = txn_addr;
        txn_wdata_nx    = txn_wdata;
        phase_end       = (cnt == WAIT_LAST);

        case (state)
            IDLE: begin
                // Data wins unless both request and data was the previous owner.
                if (d_req && (!i_req || !last_grant_d)) begin
                    grant_d_nx      = 1'b1;
                    last_grant_d_nx = 1'b1;
                    txn_we_nx       = d_we;
                    txn_addr_nx     = d_addr[ADDR_W:2];
                    txn_wdata_nx    = d_wdata;
                    state_nx        = LOW;
                    cnt_nx          = 4'd0;
                end else if (i_req) begin
                    grant_d_nx      = 1'b0;
                    last_grant_d_nx = 1'b0;
                    txn_we_nx       = 1'b0;
                    txn_addr_nx     = i_addr[ADDR_W:2];
                    state_nx        = LOW;
                    cnt_nx          = 4'd0;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_nx = HIGH;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_nx = DONE;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase

        // SRAM pins are registered from next-state values so they change cleanly on the
        // edge that enters each cycle; the last cycle of a write phase holds data with we_n high.
        busy_nx = (state_nx == LOW) || (state_nx == HIGH);
        half_nx = (state_nx == HIGH);
        we_n_nx = !(busy_nx && txn_we_nx && (cnt_nx < WAIT_LAST));
        oe_nx   = busy_nx && txn_we_nx;
        ack_nx  = (state == HIGH) && phase_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            grant_d      <= 1'b0;
            last_grant_d <= 1'b0;
            txn_we       <= 1'b0;
            txn_addr     <= '0;
            txn_wdata    <= 32'd0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            grant_d      <= grant_d_nx;
            last_grant_d <= last_grant_d_nx;
            txn_we       <= txn_we_nx;
            txn_addr     <= txn_addr_nx;
            txn_wdata    <= txn_wdata_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
        end else begin
            sram_we_n  <= we_n_nx;
            sram_dq_oe <= oe_nx;
            if (busy_nx) begin
                sram_addr <= {txn_addr_nx, half_nx};
            end
            if (busy_nx && txn_we_nx) begin
                sram_dq_out <= half_nx ? txn_wdata_nx[31:16] : txn_wdata_nx[15:0];
            end
        end
    end

    // Read halves are sampled on the last cycle of each phase, after the wait states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_lo   <= 16'd0;
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
        end else begin
            i_ack <= ack_nx && !grant_d;
            d_ack <= ack_nx && grant_d;
            if ((state == LOW) && phase_end && !txn_we) begin
                rd_lo <= sram_dq_in;
            end
            if ((state == HIGH) && phase_end && !txn_we) begin
                if (grant_d) begin
                    d_rdata <= {sram_dq_in, rd_lo};
                end else begin
                    i_rdata <= {sram_dq_in, rd_lo};
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a WAIT_CYCLES=1 instance for the main tests and a
// WAIT_CYCLES=3 instance for phase-length checks, each with its own small SRAM model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_ack, d_ack, d_ready, sram_dq_oe, sram_we_n;
    logic [31:0] i_rdata, d_rdata;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic [1:0]  state_dbg;

    logic        i_req2 = 1'b0, d_req2 = 1'b0, d_we2 = 1'b0;
    logic [31:0] i_addr2 = '0, d_addr2 = '0, d_wdata2 = '0;
    logic        i_ack2, d_ack2, d_ready2, sram_dq_oe2, sram_we_n2;
    logic [31:0] i_rdata2, d_rdata2;
    logic [17:0] sram_addr2;
    logic [15:0] sram_dq_out2, sram_dq_in2;
    logic [1:0]  state_dbg2;

    logic [15:0] mem  [0:255];
    logic [15:0] mem2 [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    sram_arbiter #(.ADDR_W(18), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_ready(d_ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .state_dbg(state_dbg)
    );

    sram_arbiter #(.ADDR_W(18), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req2), .i_addr(i_addr2), .i_ack(i_ack2), .i_rdata(i_rdata2),
        .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_ack(d_ack2), .d_rdata(d_rdata2), .d_ready(d_ready2),
        .sram_addr(sram_addr2), .sram_dq_out(sram_dq_out2), .sram_dq_in(sram_dq_in2),
        .sram_dq_oe(sram_dq_oe2), .sram_we_n(sram_we_n2), .state_dbg(state_dbg2)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM models ----------------
    assign sram_dq_in  = mem[sram_addr[7:0]];
    assign sram_dq_in2 = mem2[sram_addr2[7:0]];

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[7:0]] = sram_dq_out;
        if (!sram_we_n2) mem2[sram_addr2[7:0]] = sram_dq_out2;
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        scramble;
    } txn_t;

    typedef struct {
        logic        chk_bus;
        logic [17:0] addr;
        logic [15:0] dq;
        logic        we_n;
        logic        oe;
        logic        ack;
        logic        ready;
    } trace_t;

    txn_t   tbl [10];
    trace_t tr  [5];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_txn(input int idx, input txn_t t);
        int edges, we_lows;
        logic oe_seen, other_ack, got;
        edges = 0; we_lows = 0; oe_seen = 1'b0; other_ack = 1'b0; got = 1'b0;
        if (t.is_d) begin
            d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
        end else begin
            i_req = 1'b1; i_addr = t.addr;
        end
        while (!got && edges < 20) begin
            tick();
            edges++;
            if (edges == 1 && t.scramble) begin
                if (t.is_d) begin
                    d_addr = ~t.addr; d_wdata = ~t.wdata;
                end else begin
                    i_addr = ~t.addr;
                end
            end
            if (!sram_we_n) we_lows++;
            if (sram_dq_oe) oe_seen = 1'b1;
            if (t.is_d ? i_ack : d_ack) other_ack = 1'b1;
            got = t.is_d ? d_ack : i_ack;
        end
        check($sformatf("txn%0d_ack_seen", idx), 32'(got), 32'd1);
        check($sformatf("txn%0d_latency", idx), 32'(edges), 32'd5);
        if (!t.we)
            check($sformatf("txn%0d_rdata", idx), t.is_d ? d_rdata : i_rdata, t.exp_rdata);
        check($sformatf("txn%0d_we_low_cycles", idx), 32'(we_lows), t.we ? 32'd2 : 32'd0);
        check($sformatf("txn%0d_oe_seen", idx), 32'(oe_seen), 32'(t.we));
        check($sformatf("txn%0d_other_ack", idx), 32'(other_ack), 32'd0);
        d_req = 1'b0; i_req = 1'b0;
        tick();
        check($sformatf("txn%0d_ack_one_cycle", idx), 32'(t.is_d ? d_ack : i_ack), 32'd0);
    endtask

    task automatic run_w3(input int idx, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp);
        int edges, we_lows;
        logic got;
        logic [17:0] base;
        base = {addr[18:2], 1'b0};
        edges = 0; we_lows = 0; got = 1'b0;
        d_req2 = 1'b1; d_we2 = we; d_addr2 = addr; d_wdata2 = wdata;
        #1;
        check($sformatf("w3_%0d_ready_at_req", idx), 32'(d_ready2), 32'd0);
        while (!got && edges < 20) begin
            tick();
            edges++;
            got = d_ack2;
            if (!sram_we_n2) we_lows++;
            if (!got) begin
                check($sformatf("w3_%0d_addr_e%0d", idx, edges), 32'(sram_addr2),
                      (edges <= 4) ? 32'(base) : 32'(base) + 32'd1);
                check($sformatf("w3_%0d_ready_e%0d", idx, edges), 32'(d_ready2), 32'd0);
            end else begin
                check($sformatf("w3_%0d_ready_at_ack", idx), 32'(d_ready2), 32'd1);
            end
        end
        check($sformatf("w3_%0d_ack_seen", idx), 32'(got), 32'd1);
        check($sformatf("w3_%0d_latency", idx), 32'(edges), 32'd9);
        check($sformatf("w3_%0d_we_low_cycles", idx), 32'(we_lows), we ? 32'd6 : 32'd0);
        if (!we) check($sformatf("w3_%0d_rdata", idx), d_rdata2, exp);
        d_req2 = 1'b0;
        tick();
        check($sformatf("w3_%0d_ack_one_cycle", idx), 32'(d_ack2), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [0:0] exp_q [$];
        int cyc, last_t, nacks, d_cnt, t_d, t_i;

        for (int i = 0; i < 256; i++) begin
            mem[i]  = 16'h0000;
            mem2[i] = 16'h0000;
        end
        mem[2]   = 16'h1234;
        mem[3]   = 16'hABCD;
        mem2[16] = 16'h5555;
        mem2[17] = 16'h6666;

        //             chk  addr     dq        we_n  oe    ack   ready
        tr[0] = '{1'b1, 18'h8, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
        tr[1] = '{1'b1, 18'h8, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0};
        tr[2] = '{1'b1, 18'h9, 16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0};
        tr[3] = '{1'b1, 18'h9, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0};
        tr[4] = '{1'b0, 18'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};

        //         is_d  we    addr           wdata          exp_rdata      scramble
        tbl[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'hABCD_1234, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0123_4567, 32'h0,         1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0123_4567, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0006, 32'h0,         32'hABCD_1234, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         1'b0};
        tbl[6] = '{1'b0, 1'b0, 32'h0000_03FF, 32'h0,         32'hCAFE_F00D, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222, 32'h0,         1'b1};
        tbl[8] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h1111_2222, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h0123_4567, 1'b0};

        // reset values
        repeat (2) @(negedge clk);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check("rst_i_ack", 32'(i_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_w3_we_n", 32'(sram_we_n2), 32'd1);
        rst = 1'b0;
        tick();

        // cycle-by-cycle write trace: 0xDEADBEEF to byte address 0x10
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (tr[k].chk_bus) begin
                check($sformatf("wtrace%0d_addr", k), 32'(sram_addr), 32'(tr[k].addr));
                check($sformatf("wtrace%0d_dq", k), 32'(sram_dq_out), 32'(tr[k].dq));
            end
            check($sformatf("wtrace%0d_we_n", k), 32'(sram_we_n), 32'(tr[k].we_n));
            check($sformatf("wtrace%0d_oe", k), 32'(sram_dq_oe), 32'(tr[k].oe));
            check($sformatf("wtrace%0d_ack", k), 32'(d_ack), 32'(tr[k].ack));
            check($sformatf("wtrace%0d_ready", k), 32'(d_ready), 32'(tr[k].ready));
            if (tr[k].ack) d_req = 1'b0;
        end
        tick();
        check("wtrace_ack_drop", 32'(d_ack), 32'd0);
        check("wtrace_mem_lo", 32'(mem[8]), 32'h0000_BEEF);
        check("wtrace_mem_hi", 32'(mem[9]), 32'h0000_DEAD);

        // table of single-port transactions
        for (int i = 0; i < 10; i++) run_txn(i, tbl[i]);

        // both ports requesting continuously from reset: D, I, D, I every 6 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        i_req = 1'b1; i_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        cyc = 0; last_t = -1; nacks = 0;
        while (nacks < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (d_ack || i_ack) begin
                check($sformatf("both%0d_not_both", nacks), 32'(d_ack & i_ack), 32'd0);
                check($sformatf("both%0d_is_data", nacks), 32'(d_ack), 32'(exp_q.pop_front()));
                if (d_ack) check($sformatf("both%0d_d_rdata", nacks), d_rdata, 32'hDEAD_BEEF);
                else       check($sformatf("both%0d_i_rdata", nacks), i_rdata, 32'hABCD_1234);
                if (last_t >= 0) check($sformatf("both%0d_spacing", nacks), 32'(cyc - last_t), 32'd6);
                last_t = cyc;
                nacks++;
            end
        end
        check("both_ack_count", 32'(nacks), 32'd4);
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // reset asserted during the first LOW write cycle
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h7777_8888;
        tick();
        check("rstw_pre_we_n", 32'(sram_we_n), 32'd0);
        check("rstw_pre_oe", 32'(sram_dq_oe), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstw_async_we_n", 32'(sram_we_n), 32'd1);
        check("rstw_async_oe", 32'(sram_dq_oe), 32'd0);
        @(negedge clk);
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        nacks = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (d_ack || i_ack) nacks++;
        end
        check("rstw_no_ack", 32'(nacks), 32'd0);
        check("rstw_idle", 32'(state_dbg), 32'd0);
        check("rstw_mem_untouched", 32'(mem[8'h40]), 32'd0);
        run_txn(20, '{1'b1, 1'b1, 32'h80, 32'h7777_8888, 32'h0, 1'b0});
        run_txn(21, '{1'b1, 1'b0, 32'h80, 32'h0, 32'h7777_8888, 1'b0});

        // d_req dropped one cycle after acceptance, i_req pending behind it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        d_cnt = 0; t_d = -1; t_i = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) begin i_req = 1'b1; i_addr = 32'h4; end
            if (c == 2) d_req = 1'b0;
            if (d_ack) begin
                d_cnt++;
                t_d = c;
                check("drop_d_rdata", d_rdata, 32'hDEAD_BEEF);
            end
            if (i_ack) begin
                t_i = c;
                i_req = 1'b0;
                check("drop_i_rdata", i_rdata, 32'hABCD_1234);
            end
        end
        check("drop_d_ack_count", 32'(d_cnt), 32'd1);
        check("drop_d_ack_time", 32'(t_d), 32'd5);
        check("drop_i_ack_time", 32'(t_i), 32'd11);

        // WAIT_CYCLES = 3 instance
        run_w3(0, 1'b0, 32'h20, 32'h0, 32'h6666_5555);
        run_w3(1, 1'b1, 32'h24, 32'h1357_9BDF, 32'h0);
        run_w3(2, 1'b0, 32'h24, 32'h0, 32'h1357_9BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
